// File: rtl/alu_decode_stage.sv
// alu_decode_stage: registered RV32I decode stage feeding the ALU.
// Decodes OP, OP-IMM and LUI into ALU control fields and register indices,
// holds them in one output register behind a valid/ready handshake, and
// keeps a saturating count of accepted illegal instructions.
//
// Ports:
//   clk, rst             rising-edge clock, synchronous active-high reset
//   flush                drop the held entry and any entry accepted this cycle
//   in_valid/in_ready    upstream handshake, instr is the RV32I word
//   out_valid/out_ready  downstream handshake for the decoded fields
//   alu_operation        4-bit ALU opcode
//   alu_immediate_enable operand 2 comes from immediate_data
//   immediate_data       sign-extended I immediate or U immediate
//   alu_shamt            immediate shift amount (0 when not an immediate shift)
//   shamt_from_reg       register shift, shamt comes from rs2 data
//   rs1_addr/rs2_addr/rd_addr, rd_write_enable
//   illegal_instr        held instruction is unsupported or malformed
//   illegal_count        saturating count of accepted illegal instructions
module alu_decode_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  alu_operation,
  output logic        alu_immediate_enable,
  output logic [31:0] immediate_data,
  output logic [4:0]  alu_shamt,
  output logic        shamt_from_reg,
  output logic [4:0]  rs1_addr,
  output logic [4:0]  rs2_addr,
  output logic [4:0]  rd_addr,
  output logic        rd_write_enable,
  output logic        illegal_instr,
  output logic [15:0] illegal_count
);

  localparam int unsigned XLEN   = 32;
  localparam int unsigned OPW    = 4;
  localparam int unsigned REGW   = 5;
  localparam int unsigned CNTW   = 16;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [OPW-1:0] ALU_ADD  = 4'b0000;
  localparam logic [OPW-1:0] ALU_SUB  = 4'b0001;
  localparam logic [OPW-1:0] ALU_SLL  = 4'b0010;
  localparam logic [OPW-1:0] ALU_SLT  = 4'b0011;
  localparam logic [OPW-1:0] ALU_SLTU = 4'b0100;
  localparam logic [OPW-1:0] ALU_XOR  = 4'b0101;
  localparam logic [OPW-1:0] ALU_SRA  = 4'b0110;
  localparam logic [OPW-1:0] ALU_SRL  = 4'b0111;
  localparam logic [OPW-1:0] ALU_OR   = 4'b1000;
  localparam logic [OPW-1:0] ALU_AND  = 4'b1001;

  localparam logic [CNTW-1:0] CNT_MAX = '1;

  // Instruction field slices
  logic [6:0]      w_opcode;
  logic [2:0]      w_funct3;
  logic [6:0]      w_funct7;
  logic [REGW-1:0] w_rs1_f;
  logic [REGW-1:0] w_rs2_f;
  logic [REGW-1:0] w_rd_f;

  assign w_opcode = instr[6:0];
  assign w_rd_f   = instr[11:7];
  assign w_funct3 = instr[14:12];
  assign w_rs1_f  = instr[19:15];
  assign w_rs2_f  = instr[24:20];
  assign w_funct7 = instr[31:25];

  // Decoded fields for the incoming word
  logic [OPW-1:0]  w_op;
  logic            w_imm_en;
  logic [XLEN-1:0] w_imm;
  logic [REGW-1:0] w_shamt;
  logic            w_sfr;
  logic [REGW-1:0] w_rs1;
  logic [REGW-1:0] w_rs2;
  logic [REGW-1:0] w_rd;
  logic            w_we;
  logic            w_ill;
  logic            w_accept;

  // Output register
  logic            r_valid;
  logic [OPW-1:0]  r_op;
  logic            r_imm_en;
  logic [XLEN-1:0] r_imm;
  logic [REGW-1:0] r_shamt;
  logic            r_sfr;
  logic [REGW-1:0] r_rs1;
  logic [REGW-1:0] r_rs2;
  logic [REGW-1:0] r_rd;
  logic            r_we;
  logic            r_ill;
  logic [CNTW-1:0] r_count;

  // funct7=0000000 / OP-IMM funct3 mapping; 101 defaults to the logical shift
  function automatic logic [OPW-1:0] f3_to_op(input logic [2:0] f3);
    logic [OPW-1:0] op;
    case (f3)
      3'b000:  op = ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  assign in_ready = !rst && (!r_valid || out_ready);
  assign w_accept = in_valid && in_ready;

  // Combinational decode of instr
  always_comb begin
    w_op     = ALU_ADD;
    w_imm_en = 1'b0;
    w_imm    = '0;
    w_shamt  = '0;
    w_sfr    = 1'b0;
    w_rs1    = '0;
    w_rs2    = '0;
    w_rd     = '0;
    w_we     = 1'b0;
    w_ill    = 1'b0;

    case (w_opcode)
      OPC_OP: begin
        w_rs1 = w_rs1_f;
        w_rs2 = w_rs2_f;
        w_rd  = w_rd_f;
        w_we  = 1'b1;
        if (w_funct7 == F7_BASE) begin
          w_op  = f3_to_op(w_funct3);
          w_sfr = (w_funct3 == 3'b001) || (w_funct3 == 3'b101);
        end else if (w_funct7 == F7_ALT && w_funct3 == 3'b000) begin
          w_op = ALU_SUB;
        end else if (w_funct7 == F7_ALT && w_funct3 == 3'b101) begin
          w_op  = ALU_SRA;
          w_sfr = 1'b1;
        end else begin
          w_ill = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        w_imm_en = 1'b1;
        w_imm    = XLEN'({{20{instr[31]}}, instr[31:20]});
        w_rs1    = w_rs1_f;
        w_rd     = w_rd_f;
        w_we     = 1'b1;
        w_op     = f3_to_op(w_funct3);
        // Immediate shifts reuse imm[11:5] as a funct7 qualifier
        if (w_funct3 == 3'b001) begin
          w_shamt = w_rs2_f;
          if (w_funct7 != F7_BASE) w_ill = 1'b1;
        end else if (w_funct3 == 3'b101) begin
          w_shamt = w_rs2_f;
          if (w_funct7 == F7_ALT)       w_op  = ALU_SRA;
          else if (w_funct7 != F7_BASE) w_ill = 1'b1;
        end
      end
      OPC_LUI: begin
        w_imm_en = 1'b1;
        w_imm    = {instr[31:12], 12'b0};
        w_rd     = w_rd_f;
        w_we     = 1'b1;
      end
      default: w_ill = 1'b1;
    endcase

    // Illegal words present only the flag
    if (w_ill) begin
      w_op     = ALU_ADD;
      w_imm_en = 1'b0;
      w_imm    = '0;
      w_shamt  = '0;
      w_sfr    = 1'b0;
      w_rs1    = '0;
      w_rs2    = '0;
      w_rd     = '0;
      w_we     = 1'b0;
    end
  end

  // Output pipeline register; flush wins over load and consume
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid  <= 1'b0;
      r_op     <= '0;
      r_imm_en <= 1'b0;
      r_imm    <= '0;
      r_shamt  <= '0;
      r_sfr    <= 1'b0;
      r_rs1    <= '0;
      r_rs2    <= '0;
      r_rd     <= '0;
      r_we     <= 1'b0;
      r_ill    <= 1'b0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_valid  <= 1'b1;
      r_op     <= w_op;
      r_imm_en <= w_imm_en;
      r_imm    <= w_imm;
      r_shamt  <= w_shamt;
      r_sfr    <= w_sfr;
      r_rs1    <= w_rs1;
      r_rs2    <= w_rs2;
      r_rd     <= w_rd;
      r_we     <= w_we;
      r_ill    <= w_ill;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

  // Illegal counter counts every accepted illegal word, flushed or not
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (w_accept && w_ill && r_count != CNT_MAX) begin
      r_count <= r_count + CNTW'(1);
    end
  end

  assign out_valid            = r_valid;
  assign alu_operation        = r_op;
  assign alu_immediate_enable = r_imm_en;
  assign immediate_data       = r_imm;
  assign alu_shamt            = r_shamt;
  assign shamt_from_reg       = r_sfr;
  assign rs1_addr             = r_rs1;
  assign rs2_addr             = r_rs2;
  assign rd_addr              = r_rd;
  assign rd_write_enable      = r_we;
  assign illegal_instr        = r_ill;
  assign illegal_count        = r_count;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Directed testbench for alu_decode_stage with hand-computed expectations.
module tb_alu_decode_stage;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  alu_operation;
  logic        alu_immediate_enable;
  logic [31:0] immediate_data;
  logic [4:0]  alu_shamt;
  logic        shamt_from_reg;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [4:0]  rd_addr;
  logic        rd_write_enable;
  logic        illegal_instr;
  logic [15:0] illegal_count;

  int total = 0;
  int bad   = 0;

  alu_decode_stage dut (
    .clk                  (clk),
    .rst                  (rst),
    .flush                (flush),
    .in_valid             (in_valid),
    .in_ready             (in_ready),
    .instr                (instr),
    .out_valid            (out_valid),
    .out_ready            (out_ready),
    .alu_operation        (alu_operation),
    .alu_immediate_enable (alu_immediate_enable),
    .immediate_data       (immediate_data),
    .alu_shamt            (alu_shamt),
    .shamt_from_reg       (shamt_from_reg),
    .rs1_addr             (rs1_addr),
    .rs2_addr             (rs2_addr),
    .rd_addr              (rd_addr),
    .rd_write_enable      (rd_write_enable),
    .illegal_instr        (illegal_instr),
    .illegal_count        (illegal_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one clock edge and settle just after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    instr     = 32'h0;
    out_ready = 1'b0;
    step();
    step();

    // Reset state
    chk("rst_valid",  32'(out_valid), 32'h0);
    chk("rst_ready",  32'(in_ready), 32'h0);
    chk("rst_count",  32'(illegal_count), 32'h0);
    chk("rst_op",     32'(alu_operation), 32'h0);
    chk("rst_imm",    immediate_data, 32'h0);
    rst = 1'b0;
    #1;
    chk("ready_idle", 32'(in_ready), 32'h1);

    // add x3,x1,x2
    out_ready = 1'b1;
    in_valid  = 1'b1;
    instr     = 32'h002081B3;
    step();
    in_valid = 1'b0;
    chk("add_valid", 32'(out_valid), 32'h1);
    chk("add_op",    32'(alu_operation), 32'h0);
    chk("add_rs1",   32'(rs1_addr), 32'd1);
    chk("add_rs2",   32'(rs2_addr), 32'd2);
    chk("add_rd",    32'(rd_addr), 32'd3);
    chk("add_immen", 32'(alu_immediate_enable), 32'h0);
    chk("add_sfr",   32'(shamt_from_reg), 32'h0);
    chk("add_we",    32'(rd_write_enable), 32'h1);
    chk("add_ill",   32'(illegal_instr), 32'h0);

    // sub x5,x6,x7 then addi x1,x0,-1 back to back
    in_valid = 1'b1;
    instr    = 32'h407302B3;
    step();
    chk("sub_op",  32'(alu_operation), 32'h1);
    chk("sub_rs1", 32'(rs1_addr), 32'd6);
    chk("sub_rs2", 32'(rs2_addr), 32'd7);
    chk("sub_rd",  32'(rd_addr), 32'd5);
    instr = 32'hFFF00093;
    step();
    chk("addi_valid", 32'(out_valid), 32'h1);
    chk("addi_op",    32'(alu_operation), 32'h0);
    chk("addi_immen", 32'(alu_immediate_enable), 32'h1);
    chk("addi_imm",   immediate_data, 32'hFFFFFFFF);
    chk("addi_rd",    32'(rd_addr), 32'd1);
    chk("addi_rs2",   32'(rs2_addr), 32'd0);

    // srai x2,x1,3
    instr = 32'h4030D113;
    step();
    chk("srai_op",    32'(alu_operation), 32'h6);
    chk("srai_shamt", 32'(alu_shamt), 32'd3);
    chk("srai_sfr",   32'(shamt_from_reg), 32'h0);
    chk("srai_imm",   immediate_data, 32'h00000403);
    chk("srai_rd",    32'(rd_addr), 32'd2);
    chk("srai_rs1",   32'(rs1_addr), 32'd1);

    // lui x4,0x12345
    instr = 32'h12345237;
    step();
    chk("lui_imm",   immediate_data, 32'h12345000);
    chk("lui_rs1",   32'(rs1_addr), 32'd0);
    chk("lui_op",    32'(alu_operation), 32'h0);
    chk("lui_rd",    32'(rd_addr), 32'd4);
    chk("lui_immen", 32'(alu_immediate_enable), 32'h1);
    chk("lui_shamt", 32'(alu_shamt), 32'd0);

    // Register shifts: sll, srl, sra
    instr = 32'h002091B3;
    step();
    chk("sll_op",  32'(alu_operation), 32'h2);
    chk("sll_sfr", 32'(shamt_from_reg), 32'h1);
    instr = 32'h0020D1B3;
    step();
    chk("srl_op",  32'(alu_operation), 32'h7);
    chk("srl_sfr", 32'(shamt_from_reg), 32'h1);
    instr = 32'h4020D1B3;
    step();
    chk("sra_op",    32'(alu_operation), 32'h6);
    chk("sra_sfr",   32'(shamt_from_reg), 32'h1);
    chk("sra_shamt", 32'(alu_shamt), 32'd0);

    // Consume with no new input drops out_valid
    in_valid = 1'b0;
    step();
    chk("bubble_valid", 32'(out_valid), 32'h0);

    // Backpressure: and x4,x5,x6 held while or x7,x1,x2 waits
    out_ready = 1'b0;
    in_valid  = 1'b1;
    instr     = 32'h0062F233;
    step();
    instr = 32'h0020E3B3;
    for (int i = 0; i < 5; i++) begin
      chk("bp_ready", 32'(in_ready), 32'h0);
      chk("bp_valid", 32'(out_valid), 32'h1);
      chk("bp_op",    32'(alu_operation), 32'h9);
      chk("bp_rd",    32'(rd_addr), 32'd4);
      step();
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(in_ready), 32'h1);
    step();
    chk("bp_new_valid", 32'(out_valid), 32'h1);
    chk("bp_new_op",    32'(alu_operation), 32'h8);
    chk("bp_new_rd",    32'(rd_addr), 32'd7);

    // Illegal encodings
    instr = 32'h00000000;
    step();
    chk("ill0_ill", 32'(illegal_instr), 32'h1);
    chk("ill0_we",  32'(rd_write_enable), 32'h0);
    chk("ill0_cnt", 32'(illegal_count), 32'd1);
    instr = 32'h4020F1B3;
    step();
    chk("ill1_ill", 32'(illegal_instr), 32'h1);
    chk("ill1_we",  32'(rd_write_enable), 32'h0);
    chk("ill1_rd",  32'(rd_addr), 32'd0);
    chk("ill1_rs1", 32'(rs1_addr), 32'd0);
    chk("ill1_cnt", 32'(illegal_count), 32'd2);
    instr = 32'h00000013;
    step();
    chk("nop_ill", 32'(illegal_instr), 32'h0);
    chk("nop_we",  32'(rd_write_enable), 32'h1);
    chk("nop_rd",  32'(rd_addr), 32'd0);
    chk("nop_cnt", 32'(illegal_count), 32'd2);
    // slli with funct7 0100000 is malformed
    instr = 32'h40001013;
    step();
    chk("slli_bad_ill", 32'(illegal_instr), 32'h1);
    chk("slli_bad_cnt", 32'(illegal_count), 32'd3);

    // Flush with an entry held plus a new (illegal) accept
    out_ready = 1'b0;
    instr     = 32'h002081B3;
    step();
    chk("pre_flush_valid", 32'(out_valid), 32'h1);
    flush     = 1'b1;
    out_ready = 1'b1;
    instr     = 32'h00000000;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush_valid", 32'(out_valid), 32'h0);
    chk("flush_cnt",   32'(illegal_count), 32'd4);
    step();
    chk("flush_valid2", 32'(out_valid), 32'h0);

    // Saturation: 65540 illegal accepts on top of count 4
    in_valid = 1'b1;
    instr    = 32'h00000000;
    for (int i = 0; i < 65530; i++) step();
    chk("sat_fffe", 32'(illegal_count), 32'h0000FFFE);
    step();
    chk("sat_ffff", 32'(illegal_count), 32'h0000FFFF);
    for (int i = 0; i < 9; i++) step();
    chk("sat_hold", 32'(illegal_count), 32'h0000FFFF);

    // Reset mid-stall
    out_ready = 1'b0;
    instr     = 32'h0062F233;
    step();
    chk("stall_valid", 32'(out_valid), 32'h1);
    rst = 1'b1;
    #1;
    chk("rst_ready_hi", 32'(in_ready), 32'h0);
    step();
    chk("mid_rst_valid", 32'(out_valid), 32'h0);
    chk("mid_rst_ill",   32'(illegal_instr), 32'h0);
    chk("mid_rst_cnt",   32'(illegal_count), 32'h0);
    chk("mid_rst_op",    32'(alu_operation), 32'h0);
    chk("mid_rst_rd",    32'(rd_addr), 32'h0);
    chk("mid_rst_we",    32'(rd_write_enable), 32'h0);
    chk("mid_rst_imm",   immediate_data, 32'h0);
    chk("mid_rst_ready", 32'(in_ready), 32'h0);
    rst      = 1'b0;
    in_valid = 1'b0;
    step();
    chk("post_rst_valid", 32'(out_valid), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_decode_stage.md
# alu_decode_stage

Registered decode stage that sits directly upstream of the ALU. It accepts RV32I instruction words over a valid/ready handshake and decodes OP, OP-IMM and LUI into the ALU control fields plus register addresses. Results are held in a single output pipeline register. It also flags unsupported encodings and keeps a saturating count of them.

## Interface
- No parameters; all widths fixed for RV32I.
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- flush  in  1  discard the held and the incoming instruction
- in_valid  in  1  instr is valid
- in_ready  out  1  stage can accept instr this cycle
- instr  in  32  RV32I instruction word
- out_valid  out  1  decoded fields valid
- out_ready  in  1  consumer accepts decoded fields
- alu_operation  out  4  0000 add, 0001 sub, 0010 sll, 0011 slt, 0100 sltu, 0101 xor, 0110 sra, 0111 srl, 1000 or, 1001 and
- alu_immediate_enable  out  1  ALU operand 2 is immediate_data
- immediate_data  out  32  sign-extended I immediate, or U immediate
- alu_shamt  out  5  shift amount for immediate shifts; 0 otherwise
- shamt_from_reg  out  1  register shift: consumer drives ALU shamt from rs2 data[4:0]
- rs1_addr, rs2_addr, rd_addr  out  5 each  register indices
- rd_write_enable  out  1  result must be written to rd
- illegal_instr  out  1  held instruction unsupported or malformed
- illegal_count  out  16  saturating count of illegal instructions accepted

## Operation
**Handshake**
- in_ready = !rst && (!out_valid || out_ready).
- An instruction is accepted when in_valid && in_ready.

**Opcode 0110011 (OP)**
- alu_immediate_enable=0, immediate_data=0, rd_write_enable=1.
- rs1/rs2/rd taken from instr[19:15]/[24:20]/[11:7].
- funct7 0000000: funct3 000 add, 001 sll, 010 slt, 011 sltu, 100 xor, 101 srl, 110 or, 111 and.
- funct7 0100000: only funct3 000 (sub) and 101 (sra) are legal.
- Any other funct7, or funct7 0100000 with any other funct3, is illegal.
- shamt_from_reg=1 for sll/srl/sra; 0 for all other operations.

**Opcode 0010011 (OP-IMM)**
- alu_immediate_enable=1, rs2_addr=0, rd_write_enable=1.
- immediate_data = sign-extend(instr[31:20]).
- funct3 mapping is the same as OP, except 000 is always add (never sub).
- Shifts (001, 101):
  - alu_shamt = instr[24:20].
  - instr[31:25] must be 0000000 (slli/srli) or, for 101 only, 0100000 (srai). Any other value is illegal.
  - shamt_from_reg=0.

**Opcode 0110111 (LUI)**
- alu_operation=0000, rs1_addr=0, rs2_addr=0, alu_immediate_enable=1, rd_write_enable=1.
- immediate_data = {instr[31:12], 12'b0}.

**Any other opcode, or an illegal case above**
- illegal_instr=1, rd_write_enable=0, all other decoded fields 0.

**illegal_count**
- Increments by 1 on acceptance of an illegal instruction.
- Saturates at 0xFFFF.
- Not affected by flush; cleared only by rst.

## Timing
- Latency is 1 cycle. An instruction accepted at edge N presents out_valid=1 with its fields after edge N.
- Output fields are stable while out_valid && !out_ready.
- out_valid stays high and the fields hold until the consumer handshakes.
- Same-cycle consume and accept (out_ready=1, in_valid=1, out_valid=1) replaces the held entry with no bubble. Full throughput is 1 instruction/cycle.
- Consume with no new input: out_valid goes to 0 at the next edge.
- Flush takes priority over everything except rst:
  - out_valid is 0 at the next edge.
  - An instruction accepted in the flush cycle is discarded.
  - illegal_count is still updated for it, because it was accepted.
- rst at any edge, including mid-stall:
  - All outputs become 0 (out_valid=0, illegal_instr=0, illegal_count=0, all fields 0).
  - in_ready is 0 while rst is high.
- rd_addr=0 with rd_write_enable=1 is legal; the register file ignores writes to x0.

## Test plan
- 0x002081B3 (add x3,x1,x2), out_ready=1 → next cycle: op 0000, rs1=1, rs2=2, rd=3, imm_en=0, shamt_from_reg=0, rd_we=1.
- 0x407302B3 (sub x5,x6,x7), then 0xFFF00093 (addi x1,x0,-1) back-to-back → op 0001 for the first; then op 0000, imm_en=1, imm 0xFFFFFFFF, rd=1. Nothing dropped.
- 0x4030D113 (srai x2,x1,3) → op 0110, alu_shamt=3, shamt_from_reg=0. Then 0x12345237 (lui x4,0x12345) → imm 0x12345000, rs1=0, op 0000.
- Backpressure: hold out_ready=0 for 5 cycles after one accept → in_ready=0 and fields unchanged throughout. Raise out_ready with in_valid=1 → held entry consumed and new entry captured on the same edge.
- Illegal words 0x00000000, 0x0020F1B3 with funct7 0100000 (0x4020F1B3), and 0x00000013 → illegal_instr=1 and rd_we=0 for the first two; addi (0x13) is legal. illegal_count=2. Forcing 65540 illegal accepts saturates the count at 0xFFFF.
- Flush with an entry held plus a new accept → out_valid=0 next cycle. Assert rst mid-stall → all outputs 0 and in_ready=0 during reset.
